// File: rtl/pipeline_hazard_ctrl.sv
// Stall / flush / forwarding controller for the 5-stage LC-3b pipeline.
// Control outputs are combinational from the FSM state and the current
// hazard inputs; the FSM state and the two saturating perf counters are
// registered.
module pipeline_hazard_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           id_src1,
  input  logic [2:0]           id_src2,
  input  logic                 id_uses_sr1,
  input  logic                 id_uses_sr2,
  input  logic [2:0]           ex_src1,
  input  logic [2:0]           ex_src2,
  input  logic [2:0]           ex_dest,
  input  logic                 ex_regwrite,
  input  logic                 ex_mem_read,
  input  logic [2:0]           mem_dest,
  input  logic                 mem_regwrite,
  input  logic [2:0]           wb_dest,
  input  logic                 wb_regwrite,
  input  logic                 imem_req,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  input  logic                 br_taken,
  output logic                 pc_load,
  output logic                 if_id_load,
  output logic                 id_ex_load,
  output logic                 ex_mem_load,
  output logic                 mem_wb_load,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;
  logic                 dmem_stall_s;
  logic                 imem_stall_s;
  logic                 load_use_s;
  logic                 flush_evt_s;

  // Forward source selection: the younger producer (EX/MEM) beats MEM/WB.
  // R0 is an ordinary register, so tag 0 is forwarded like any other.
  function automatic logic [1:0] fwd_sel(input logic [2:0] src,
                                         input logic       m_we,
                                         input logic [2:0] m_dst,
                                         input logic       w_we,
                                         input logic [2:0] w_dst);
    logic [1:0] sel;
    if (m_we && (m_dst == src)) begin
      sel = 2'b01;
    end else if (w_we && (w_dst == src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign dmem_stall_s = dmem_req && !dmem_resp;
  assign imem_stall_s = imem_req && !imem_resp;
  assign load_use_s   = ex_mem_read && ex_regwrite &&
                        ((id_uses_sr1 && (id_src1 == ex_dest)) ||
                         (id_uses_sr2 && (id_src2 == ex_dest)));

  // Forwarding muxes, forced to the register file while in reset.
  always_comb begin
    if (reset) begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end else begin
      fwd_a = fwd_sel(ex_src1, mem_regwrite, mem_dest, wb_regwrite, wb_dest);
      fwd_b = fwd_sel(ex_src2, mem_regwrite, mem_dest, wb_regwrite, wb_dest);
    end
  end

  // Load/flush generation and next state, in hazard priority order.
  always_comb begin
    pc_load      = 1'b1;
    if_id_load   = 1'b1;
    id_ex_load   = 1'b1;
    ex_mem_load  = 1'b1;
    mem_wb_load  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    flush_evt_s  = 1'b0;
    state_d      = ST_RUN;
    if (reset) begin
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_load   = 1'b0;
      ex_mem_load  = 1'b0;
      mem_wb_load  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (dmem_stall_s) begin
      // Whole pipeline frozen; a pending branch waits for the memory op.
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      id_ex_load  = 1'b0;
      ex_mem_load = 1'b0;
      mem_wb_load = 1'b0;
      if (state_q == ST_DRAIN) begin
        // Keep discarding the wrong-path fetch while the back end waits.
        if_id_flush = 1'b1;
        state_d     = imem_resp ? ST_MEM_WAIT : ST_DRAIN;
      end else begin
        state_d = ST_MEM_WAIT;
      end
    end else if (state_q == ST_MEM_WAIT) begin
      // Data returned: one plain advance cycle before hazards resume.
      state_d = ST_RUN;
    end else if (br_taken) begin
      if_id_load   = 1'b0;
      id_ex_load   = 1'b0;
      ex_mem_load  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      flush_evt_s  = 1'b1;
      state_d      = imem_stall_s ? ST_DRAIN : ST_RUN;
    end else if (state_q == ST_DRAIN) begin
      // Wrong-path fetch still in flight: drop it, then fetch the target.
      pc_load     = imem_resp;
      if_id_load  = 1'b0;
      id_ex_load  = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = imem_resp ? ST_RUN : ST_DRAIN;
    end else if (imem_stall_s || load_use_s) begin
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      id_ex_load  = 1'b0;
      id_ex_flush = 1'b1;
      state_d     = ST_RUN;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Saturating perf counter next values.
  always_comb begin
    if (!pc_load && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end
    if (flush_evt_s && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + CNT_ONE;
    end else begin
      flush_d = flush_q;
    end
  end

  // FSM state and counters; synchronous reset drops any pending fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      stall_q <= {CNT_WIDTH{1'b0}};
      flush_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage LC-3b pipeline.
- Drives the `load` and `reset` (bubble) inputs of IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC load.
- Consumes the source and destination register tags that ID/EX and later stages hold.
- Resolves load-use hazards, memory wait states, taken-branch redirects (including draining a wrong-path I-fetch), and keeps stall/flush counters.

Parameters:
- CNT_WIDTH, 16, width of the saturating perf counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_src1, id_src2  in  3 each  source regs of the instruction in decode
- id_uses_sr1, id_uses_sr2  in  1 each  decode instruction reads that source
- ex_src1, ex_src2  in  3 each  source tags held in ID/EX
- ex_dest  in  3  dest tag held in ID/EX
- ex_regwrite, ex_mem_read  in  1 each  ID/EX instruction writes a reg / is a load (LDR, LDB, LDI)
- mem_dest, mem_regwrite  in  3, 1  EX/MEM dest tag and write-enable
- wb_dest, wb_regwrite  in  3, 1  MEM/WB dest tag and write-enable
- imem_req, imem_resp  in  1 each  I-cache request outstanding / data valid
- dmem_req, dmem_resp  in  1 each  D-cache request from MEM stage / data valid
- br_taken  in  1  taken branch/JMP/TRAP resolved in MEM stage
- pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1 each
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  drive the register's reset (bubble)
- fwd_a, fwd_b  out  2 each  00 regfile, 01 EX/MEM, 10 MEM/WB
- stall_cycles, flush_count  out  CNT_WIDTH each  saturating counters

Behaviour:
- FSM states: RUN, MEM_WAIT, DRAIN. Reset state is RUN.
- During reset: all loads=0, all flushes=1, fwd=00, counters=0.
- Control outputs are combinational from state and inputs. State and counters update on posedge clk.
- Forwarding, evaluated independently for A (ex_src1) and B (ex_src2):
  - 01 if mem_regwrite and mem_dest matches the source.
  - Else 10 if wb_regwrite and wb_dest matches.
  - Else 00.
  - EX/MEM wins over MEM/WB. R0 is a real register and is forwarded.
- Priority each cycle: dmem stall > branch > imem stall > load-use > normal.
- D-mem stall (dmem_req && !dmem_resp):
  - All loads=0, no flushes; pipeline frozen; br_taken is ignored.
  - State goes to or stays in MEM_WAIT.
  - In the cycle dmem_resp=1: normal advance, return to RUN.
- Branch (br_taken, no dmem stall):
  - pc_load=1, if_id_flush=id_ex_flush=ex_mem_flush=1, mem_wb_load=1.
  - flush_count increments.
  - If imem_req && !imem_resp in that cycle, go to DRAIN, else stay in RUN.
- DRAIN:
  - pc_load=0, if_id_flush=1; the wrong-path response is discarded.
  - id_ex_flush=1; EX/MEM and MEM/WB advance.
  - On imem_resp: pc_load=1 (fetch target), return to RUN.
  - A dmem stall in DRAIN freezes the back end but still waits for imem_resp.
- I-mem stall (imem_req && !imem_resp, RUN):
  - pc_load=if_id_load=0, id_ex_flush=1 (bubble); EX/MEM and MEM/WB advance.
- Load-use (ex_mem_read && ex_regwrite && any used id_src equal to ex_dest):
  - pc_load=if_id_load=0, id_ex_flush=1.
  - Exactly one bubble per hazard, since the load leaves ID/EX next cycle.
- Normal operation: all loads=1, all flushes=0.
- Flush outputs take priority over load in every pipeline register, so id_ex_load is don't-care when id_ex_flush=1.
- stall_cycles increments on any cycle with pc_load=0, excluding reset.
- Both counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-DRAIN: next state RUN, counters cleared, outstanding imem response ignored.

Test Plan:
- Load-use: ex_mem_read=1, ex_regwrite=1, ex_dest=3, id_src1=3, id_uses_sr1=1 -> one cycle with pc_load=0, if_id_load=0, id_ex_flush=1; next cycle all loads=1; stall_cycles=1.
- Forward priority: ex_src1=2, mem_dest=2, wb_dest=2, both regwrite=1 -> fwd_a=01. Clear mem_regwrite -> fwd_a=10. ex_src2=0, mem_dest=0, mem_regwrite=1 -> fwd_b=01.
- D-mem wait: dmem_req=1, dmem_resp=0 for 3 cycles, br_taken=1 concurrently -> all loads=0, no flush, state MEM_WAIT, flush_count unchanged. Resp cycle -> all loads=1. Following cycle, branch flush fires and flush_count=1.
- Branch with outstanding fetch: br_taken=1, imem_req=1, imem_resp=0 -> three flushes asserted, pc_load=1. Then DRAIN for 2 cycles (pc_load=0, if_id_flush=1). imem_resp=1 -> pc_load=1, RUN.
- Saturation: CNT_WIDTH=4, hold imem stall 20 cycles -> stall_cycles=15 and stays at 15.
- Reset during DRAIN -> next cycle state RUN, counters 0; reset cycle shows all flushes=1 and all loads=0.
